// File: rtl/matriz_pkg.sv
// Shared types and default constants for the column-scan matrix driver.
package matriz_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRIVE = 2'd2,
        BLANK = 2'd3
    } estado_t;

    localparam int unsigned DEF_N_COLS       = 5;
    localparam int unsigned DEF_N_ROWS       = 7;
    localparam int unsigned DEF_DRIVE_CYCLES = 4;
    localparam int unsigned DEF_BLANK_CYCLES = 2;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/matriz_varredura_contador_carga.sv
// Loadable down-counter that saturates at zero; fim_c flags terminal count.
module contador_carga #(
    parameter int unsigned W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] valor,
    output logic         fim_c
);

    logic [W-1:0] contagem;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            contagem <= '0;
        end else if (load) begin
            contagem <= valor;
        end else if (dec && (contagem != '0)) begin
            contagem <= contagem - W'(1);
        end
    end

    assign fim_c = (contagem == '0);

endmodule

// File: rtl/matriz_varredura.sv
// Column-scan driver for an LED/display matrix: LOAD, DRIVE and dead-time BLANK per column.
// Define MATRIZ_VARREDURA_BLANK_EN to include the BLANK dead-time state.
module matriz_varredura
    import matriz_pkg::*;
#(
    parameter int unsigned N_COLS       = DEF_N_COLS,
    parameter int unsigned N_ROWS       = DEF_N_ROWS,
    parameter int unsigned DRIVE_CYCLES = DEF_DRIVE_CYCLES,
    parameter int unsigned BLANK_CYCLES = DEF_BLANK_CYCLES
) (
    input  logic                      frequencia_display,
    input  logic                      reset_n,
    input  logic                      en,
    input  logic                      dir,
    input  logic [N_ROWS-1:0]         linha_in,
    output logic [$clog2(N_COLS)-1:0] col_idx,
    output logic [N_COLS-1:0]         col_sel_n,
    output logic [N_ROWS-1:0]         linha_out,
    output logic                      quadro,
    output logic                      ocupado
);

    localparam int unsigned CW    = $clog2(N_COLS);
    localparam int unsigned CNT_W = $clog2(max_u(DRIVE_CYCLES, BLANK_CYCLES) + 1);

    estado_t           estado_q;
    estado_t           estado_d;
    logic [CW-1:0]     col_idx_d;
    logic [N_COLS-1:0] col_sel_n_d;
    logic [N_ROWS-1:0] linha_out_d;
    logic              quadro_d;
    logic              ocupado_d;

    logic              cnt_load_c;
    logic              cnt_dec_c;
    logic [CNT_W-1:0]  cnt_valor_c;
    logic              cnt_fim_c;
    logic              fecha_c;
    logic [CW-1:0]     prox_idx_c;
    logic              volta_c;

    // Single dwell timer shared by DRIVE and BLANK
    contador_carga #(
        .W (CNT_W)
    ) u_contador (
        .clk   (frequencia_display),
        .rst_n (reset_n),
        .load  (cnt_load_c),
        .dec   (cnt_dec_c),
        .valor (cnt_valor_c),
        .fim_c (cnt_fim_c)
    );

    // Next column index from the current one and the live dir input; flags the wrap
    always_comb begin
        prox_idx_c = col_idx;
        volta_c    = 1'b0;
        if (dir) begin
            if (col_idx == '0) begin
                prox_idx_c = CW'(N_COLS - 1);
                volta_c    = 1'b1;
            end else begin
                prox_idx_c = col_idx - CW'(1);
            end
        end else begin
            if (col_idx == CW'(N_COLS - 1)) begin
                prox_idx_c = '0;
                volta_c    = 1'b1;
            end else begin
                prox_idx_c = col_idx + CW'(1);
            end
        end
    end

    // Next-state and next-output logic
    always_comb begin
        estado_d    = estado_q;
        col_idx_d   = col_idx;
        linha_out_d = '0;
        quadro_d    = 1'b0;
        cnt_load_c  = 1'b0;
        cnt_dec_c   = 1'b0;
        cnt_valor_c = '0;
        fecha_c     = 1'b0;
        col_sel_n_d = '1;

        case (estado_q)
            IDLE: begin
                if (en) begin
                    estado_d  = LOAD;
                    col_idx_d = dir ? CW'(N_COLS - 1) : '0;
                end
            end
            LOAD: begin
                estado_d    = DRIVE;
                linha_out_d = linha_in;
                cnt_load_c  = 1'b1;
                cnt_valor_c = CNT_W'(DRIVE_CYCLES - 1);
            end
            DRIVE: begin
                if (!cnt_fim_c) begin
                    linha_out_d = linha_out;
                    cnt_dec_c   = 1'b1;
                end else begin
`ifdef MATRIZ_VARREDURA_BLANK_EN
                    estado_d    = BLANK;
                    cnt_load_c  = 1'b1;
                    cnt_valor_c = CNT_W'(BLANK_CYCLES - 1);
`else
                    fecha_c     = 1'b1;
`endif
                end
            end
`ifdef MATRIZ_VARREDURA_BLANK_EN
            BLANK: begin
                if (!cnt_fim_c) begin
                    cnt_dec_c = 1'b1;
                end else begin
                    fecha_c   = 1'b1;
                end
            end
`endif
            default: begin
                estado_d = IDLE;
            end
        endcase

        // End of a column: advance or park; en low never moves col_idx
        if (fecha_c) begin
            if (en) begin
                estado_d  = LOAD;
                col_idx_d = prox_idx_c;
                quadro_d  = volta_c;
            end else begin
                estado_d  = IDLE;
            end
        end

        ocupado_d = (estado_d != IDLE);
        for (int i = 0; i < int'(N_COLS); i++) begin
            col_sel_n_d[i] = !((estado_d == DRIVE) && (col_idx_d == CW'(i)));
        end
    end

    // State and output registers
    always_ff @(posedge frequencia_display or negedge reset_n) begin
        if (!reset_n) begin
            estado_q  <= IDLE;
            col_idx   <= '0;
            col_sel_n <= '1;
            linha_out <= '0;
            quadro    <= 1'b0;
            ocupado   <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            col_idx   <= col_idx_d;
            col_sel_n <= col_sel_n_d;
            linha_out <= linha_out_d;
            quadro    <= quadro_d;
            ocupado   <= ocupado_d;
        end
    end

endmodule

// File: doc/matriz_varredura.md
MATRIZ_VARREDURA -- requirements
Module: matriz_varredura

Interface
REQ-001 Parameter N_COLS, default 5, number of matrix columns scanned; legal range 2 or more.
REQ-002 Parameter N_ROWS, default 7, row-drive width; legal range 1 or more.
REQ-003 Parameter DRIVE_CYCLES, default 4, clock cycles each column is driven; legal range 1 or more.
REQ-004 Parameter BLANK_CYCLES, default 2, dead-time cycles after each column; legal range 1 or more.
REQ-005 frequencia_display  in  1  sole clock, rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 en  in  1  scan enable.
REQ-008 dir  in  1  scan direction: 0 = ascending index, 1 = descending index.
REQ-009 linha_in  in  N_ROWS  row pattern for the column currently shown on col_idx.
REQ-010 col_idx  out  CW = clog2(N_COLS)  current column index.
REQ-011 col_sel_n  out  N_COLS  active-low one-hot column select; all ones when not driving.
REQ-012 linha_out  out  N_ROWS  latched row drive; all zeros when not driving.
REQ-013 quadro  out  1  one-cycle frame-complete pulse.
REQ-014 ocupado  out  1  high whenever state is not IDLE.

Function
REQ-015 The FSM SHALL have four states: IDLE, LOAD, DRIVE, BLANK; all outputs are registered.
REQ-016 In IDLE with en=1, the block SHALL go to LOAD with col_idx = 0 (dir=0) or N_COLS-1 (dir=1).
REQ-017 LOAD SHALL last one cycle: col_idx valid, col_sel_n all ones, linha_out zero; linha_in captured at the LOAD-to-DRIVE edge.
REQ-018 In DRIVE, col_sel_n[col_idx] SHALL be 0 (others 1) and linha_out SHALL hold the captured pattern for exactly DRIVE_CYCLES cycles; linha_in changes are ignored during DRIVE.
REQ-019 After the last DRIVE cycle, the block SHALL enter BLANK for BLANK_CYCLES cycles with outputs off.
REQ-020 At the end of BLANK with en=1, the block SHALL advance col_idx by one in the direction given by dir sampled at that edge, then go to LOAD.
REQ-021 Wrap-around: ascending from N_COLS-1 SHALL go to 0; descending from 0 SHALL go to N_COLS-1; quadro SHALL pulse high for the single cycle following the wrap advance.
REQ-022 A dir change mid-frame SHALL take effect at the next advance, counting from the current index, without a restart.
REQ-023 At the end of BLANK with en=0, the block SHALL go to IDLE with no advance and no quadro; col_idx SHALL then hold.
REQ-024 Deassertion of en during LOAD or DRIVE SHALL NOT truncate the current column; the column completes its DRIVE and BLANK first.
REQ-025 Column period SHALL be 1 + DRIVE_CYCLES + BLANK_CYCLES cycles; frame period SHALL be N_COLS times that.
REQ-026 Dwell counters SHALL be clog2(max(DRIVE_CYCLES, BLANK_CYCLES)+1) bits wide, with no overflow at legal parameters.

Reset
REQ-027 reset_n=0 SHALL immediately, with no clock edge required, force: state IDLE, col_idx 0, col_sel_n all ones, linha_out 0, quadro 0, ocupado 0, counters 0.
REQ-028 Reset mid-operation SHALL abandon the current column; after release, scanning restarts per REQ-016.

Configuration
REQ-029 Macro MATRIZ_VARREDURA_BLANK_EN defined: BLANK state present per REQ-019.
REQ-030 Macro undefined: BLANK state and its counter SHALL be omitted, and BLANK_CYCLES is ignored; DRIVE goes directly to the advance/IDLE decision; the column period is 1 + DRIVE_CYCLES, and LOAD is the only gap between columns.

Structure
REQ-031 Package matriz_pkg SHALL hold the FSM state enum and the default parameter constants.
REQ-032 One sub-module, contador_carga (loadable down-counter with terminal-count flag), SHALL time both DRIVE and BLANK.

Verification (N_COLS=5, N_ROWS=7, DRIVE=4, BLANK=2, macro defined unless noted)
REQ-033 Reset, then en=1, dir=0 -> col_idx 0,1,2,3,4,0, each held 7 cycles; quadro pulses exactly once per 35 cycles, after the 4 to 0 wrap.
REQ-034 dir=1 from reset -> col_idx 4,3,2,1,0,4; dir toggled to 0 during column 2 -> next index 3.
REQ-035 linha_in=1010101 in LOAD of column 2, changed to 0000000 during DRIVE -> linha_out=1010101 and col_sel_n=11011 for 4 cycles, then 0 and 11111.
REQ-036 en dropped in 2nd DRIVE cycle of column 1 -> 2 more DRIVE cycles + 2 BLANK, then ocupado=0, no quadro; en=1 again -> restart at col_idx 0.
REQ-037 reset_n pulled low mid-DRIVE with clock stopped -> col_sel_n=11111, linha_out=0, ocupado=0 at once.
REQ-038 Macro undefined -> 5-cycle column period, 25-cycle frame, col_sel_n all ones only in the LOAD cycle.
